// File: rtl/mem_arbiter.sv
// Data/fetch arbiter for one synchronous-read word memory.
// Data wins by default; a bounded wait counter hands fetch the port.
module mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e      owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [3:0]  wait_q, wait_d;
  logic        if_win;

  always_comb begin
    if_win = if_req & (~d_req | (wait_q >= WAIT_LIM));
    if_gnt = ~reset & if_win;
    d_gnt  = ~reset & d_req & ~if_win;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      if_gnt: begin
        mem_en   = 1'b1;
        mem_be   = {BE_W{1'b1}};
        mem_addr = if_addr;
      end
      d_gnt: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d  = wait_q;
    owner_d = OWN_NONE;
    wr_d    = 1'b0;
    if (!if_req || if_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q < WAIT_LIM) begin
      wait_d = wait_q + 4'd1;
    end
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt) begin
      owner_d = OWN_D;
      wr_d    = d_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      wr_q    <= 1'b0;
      wait_q  <= 4'd0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
    end
  end

  // Store acks carry no data, so the memory bus is masked for them.
  assign if_rvalid = (owner_q == OWN_IF);
  assign d_rvalid  = (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model plus a transaction-level
// reference of the grant rule and response queue.
module tb_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int          m_denied;
  int          m_pend;
  logic [31:0] m_data;

  logic        e_ifg, e_dg, e_ifv, e_dv;
  logic [31:0] e_ifd, e_dd;
  logic        e_en, e_we;
  logic [3:0]  e_be;
  logic [9:0]  e_addr;
  logic [31:0] e_wd;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic model_expect();
    e_ifg = 0; e_dg = 0; e_ifv = 0; e_dv = 0;
    e_ifd = 0; e_dd = 0;
    e_en = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
    if (!reset) begin
      if (if_req && d_req) begin
        if (m_denied >= MAXW) e_ifg = 1;
        else e_dg = 1;
      end else if (if_req) e_ifg = 1;
      else if (d_req) e_dg = 1;
      if (e_ifg) begin
        e_en = 1; e_be = 4'hF; e_addr = if_addr;
      end
      if (e_dg) begin
        e_en = 1; e_we = d_we; e_be = d_be;
        e_addr = d_addr; e_wd = d_wdata;
      end
      e_ifv = (m_pend == 1);
      e_dv  = (m_pend == 2);
      if (e_ifv) e_ifd = m_data;
      if (e_dv)  e_dd  = m_data;
    end
  endtask

  task automatic apply(input logic ir, input logic [9:0] ia,
                       input logic dr, input logic dw,
                       input logic [3:0] db, input logic [9:0] da,
                       input logic [31:0] dd);
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
    #1;
    model_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_denied = 0; m_data = 0;
    end else begin
      m_pend = 0; m_data = 0;
      if (e_ifg) begin
        m_pend = 1; m_data = ref_mem[if_addr];
      end else if (e_dg) begin
        m_pend = 2;
        if (d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
        end else m_data = ref_mem[d_addr];
      end
      if (if_req && !e_ifg)
        m_denied = (m_denied < MAXW) ? m_denied + 1 : MAXW;
      else m_denied = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_reset();
    reset = 1;
    apply(1, 3, 1, 1, 4'hF, 4, 32'h1234);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0 ||
        {mem_be, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus gnt=%b%b en=%b we=%b be=%h a=%h wd=%h want 0",
               if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_rvalid, d_rvalid} !== 2'b0 || if_rdata !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL reset_resp rv=%b%b ird=%h drd=%h want 0",
               if_rvalid, d_rvalid, if_rdata, d_rdata);
    end
    advance();
    reset = 0;
    idle();
  endtask

  task automatic test_lone_fetch();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr} !== {4'b1010, 4'hF, 10'd0}) begin
      errors++;
      $display("FAIL lone_gnt gnt=%b%b en=%b we=%b be=%h a=%h want 10 1 0 f 0",
               if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_rvalid !== 1 || if_rdata !== 32'h03208093 || d_rvalid !== 0) begin
      errors++;
      $display("FAIL lone_resp irv=%b ird=%h drv=%b want 1 03208093 0",
               if_rvalid, if_rdata, d_rvalid);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    apply(1, 1, 1, 0, 4'hF, 5, 0);
    checks++;
    if (d_gnt !== 1 || if_gnt !== 0 || mem_addr !== 10'd5) begin
      errors++;
      $display("FAIL simul_gnt dg=%b ig=%b a=%h want 1 0 5", d_gnt, if_gnt, mem_addr);
    end
    advance();
    apply(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (d_rvalid !== 1 || d_rdata !== 32'h32 || if_gnt !== 1 || if_rvalid !== 0) begin
      errors++;
      $display("FAIL simul_resp drv=%b drd=%h ig=%b irv=%b want 1 32 1 0",
               d_rvalid, d_rdata, if_gnt, if_rvalid);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_rvalid !== 1 || if_rdata !== ref_mem[1] || d_rvalid !== 0) begin
      errors++;
      $display("FAIL simul_fetch irv=%b ird=%h want 1 %h", if_rvalid, if_rdata, ref_mem[1]);
    end
    advance();
  endtask

  task automatic test_starvation();
    for (int c = 0; c < 10; c++) begin
      apply(1, 2, 1, 0, 4'hF, 10'(16 + c), 0);
      checks++;
      if (if_gnt !== (c % 5 == 4) || d_gnt !== (c % 5 != 4)) begin
        errors++;
        $display("FAIL starve_gnt cyc=%0d ig=%b dg=%b want %b %b",
                 c, if_gnt, d_gnt, c % 5 == 4, c % 5 != 4);
      end
      if (c > 0) begin
        checks++;
        if (if_rvalid !== (c % 5 == 0) || d_rvalid !== (c % 5 != 0) ||
            d_rdata !== e_dd || if_rdata !== e_ifd) begin
          errors++;
          $display("FAIL starve_resp cyc=%0d rv=%b%b ird=%h drd=%h want %b%b %h %h",
                   c, if_rvalid, d_rvalid, if_rdata, d_rdata,
                   c % 5 == 0, c % 5 != 0, e_ifd, e_dd);
        end
      end
      advance();
    end
    idle();
  endtask

  task automatic test_store_load();
    apply(0, 0, 1, 1, 4'b0011, 7, 32'hAABBCCDD);
    checks++;
    if ({d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !==
        {3'b111, 4'b0011, 10'd7, 32'hAABBCCDD}) begin
      errors++;
      $display("FAIL store_bus dg=%b en=%b we=%b be=%h a=%h wd=%h",
               d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    advance();
    apply(0, 0, 1, 0, 4'hF, 7, 0);
    checks++;
    if (d_rvalid !== 1 || d_rdata !== 0 || d_gnt !== 1) begin
      errors++;
      $display("FAIL store_ack drv=%b drd=%h dg=%b want 1 0 1", d_rvalid, d_rdata, d_gnt);
    end
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (d_rvalid !== 1 || d_rdata !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL load_after_store drv=%b drd=%h want 1 1122ccdd", d_rvalid, d_rdata);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_gnt !== 1) begin
      errors++;
      $display("FAIL rstmid_gnt ig=%b want 1", if_gnt);
    end
    reset = 1;
    #1;
    model_expect();
    checks++;
    if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid} !== 5'b0 ||
        mem_addr !== 0 || mem_be !== 0 || if_rdata !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL rstmid_zero ig=%b dg=%b en=%b be=%h a=%h rv=%b%b",
               if_gnt, d_gnt, mem_en, mem_be, mem_addr, if_rvalid, d_rvalid);
    end
    advance();
    checks++;
    if (if_rvalid !== 0 || if_rdata !== 0) begin
      errors++;
      $display("FAIL rstmid_hold irv=%b ird=%h want 0 0", if_rvalid, if_rdata);
    end
    reset = 0;
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_rvalid !== 0 || d_rvalid !== 0) begin
      errors++;
      $display("FAIL rstmid_stale rv=%b%b want 00", if_rvalid, d_rvalid);
    end
    advance();
    apply(1, 0, 0, 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if_rvalid !== 1 || if_rdata !== 32'h03208093) begin
      errors++;
      $display("FAIL rstmid_after irv=%b ird=%h want 1 03208093", if_rvalid, if_rdata);
    end
    advance();
  endtask

  task automatic test_idle_withdraw();
    apply(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mem_en, if_gnt, d_gnt} !== 3'b0) begin
      errors++;
      $display("FAIL idle en=%b gnt=%b%b want 000", mem_en, if_gnt, d_gnt);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      apply(c < 2, 9, 1, 0, 4'hF, 3, 0);
      advance();
    end
    for (int c = 0; c < 5; c++) begin
      apply(1, 9, 1, 0, 4'hF, 3, 0);
      checks++;
      if (if_gnt !== (c == 4) || d_gnt !== (c != 4)) begin
        errors++;
        $display("FAIL withdraw_gnt cyc=%0d ig=%b dg=%b want %b %b",
                 c, if_gnt, d_gnt, c == 4, c != 4);
      end
      advance();
    end
    idle();
  endtask

  task automatic test_random();
    logic        ir, dr, dw;
    logic [9:0]  ia, da;
    logic [3:0]  db;
    logic [31:0] dd;
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; db = 0; dd = 0;
    for (int n = 0; n < 400; n++) begin
      apply(ir, ia, dr, dw, db, da, dd);
      checks++;
      if ({if_gnt, d_gnt} !== {e_ifg, e_dg}) begin
        errors++;
        $display("FAIL rand_gnt n=%0d gnt=%b%b want %b%b", n, if_gnt, d_gnt, e_ifg, e_dg);
      end
      checks++;
      if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !==
          {e_en, e_we, e_be, e_addr, e_wd}) begin
        errors++;
        $display("FAIL rand_mem n=%0d en=%b we=%b be=%h a=%h wd=%h want %b %b %h %h %h",
                 n, mem_en, mem_we, mem_be, mem_addr, mem_wdata,
                 e_en, e_we, e_be, e_addr, e_wd);
      end
      checks++;
      if (if_rvalid !== e_ifv || if_rdata !== e_ifd) begin
        errors++;
        $display("FAIL rand_ifresp n=%0d v=%b d=%h want %b %h",
                 n, if_rvalid, if_rdata, e_ifv, e_ifd);
      end
      checks++;
      if (d_rvalid !== e_dv || d_rdata !== e_dd) begin
        errors++;
        $display("FAIL rand_dresp n=%0d v=%b d=%h want %b %h",
                 n, d_rvalid, d_rdata, e_dv, e_dd);
      end
      advance();
      if (e_ifg || !ir || $urandom_range(15) == 0) begin
        ir = ($urandom_range(2) != 0);
        ia = 10'($urandom_range(15));
      end
      if (e_dg || !dr || $urandom_range(15) == 0) begin
        dr = ($urandom_range(3) != 0);
        dw = $urandom_range(1) == 1;
        db = 4'($urandom_range(15));
        da = 10'($urandom_range(15));
        dd = $urandom;
      end
    end
    idle();
  endtask

  initial begin
    mem_rdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h03208093; ref_mem[0] = 32'h03208093;
    mem[5] = 32'h32;       ref_mem[5] = 32'h32;
    mem[7] = 32'h11223344; ref_mem[7] = 32'h11223344;
    m_denied = 0; m_pend = 0; m_data = 0;
    reset = 1;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_store_load();
    test_reset_mid();
    test_idle_withdraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
